// File: rtl/calc1_pkg.sv
// Shared command/response encodings, port state type and data type for the
// four-port calculator.
package calc1_pkg;

    typedef logic [31:0] data_t;
    typedef logic [3:0]  cmd_t;
    typedef logic [1:0]  resp_t;

    localparam cmd_t CMD_NOP = 4'd0;
    localparam cmd_t CMD_ADD = 4'd1;
    localparam cmd_t CMD_SUB = 4'd2;
    localparam cmd_t CMD_SHL = 4'd5;
    localparam cmd_t CMD_SHR = 4'd6;

    localparam resp_t RESP_NONE = 2'd0;
    localparam resp_t RESP_OK   = 2'd1;
    localparam resp_t RESP_ERR  = 2'd2;

    typedef enum logic {
        IDLE,
        OP2
    } port_state_t;

endpackage

// File: rtl/calc1_port.sv
// One calculator request port: two-cycle command capture, ALU and
// single-cycle registered response.
module calc1_port
    import calc1_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_cmd,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    output logic [1:0]  o_resp
);

    port_state_t r_state;
    cmd_t        r_cmd;
    data_t       r_op1;
    data_t       r_data;
    resp_t       r_resp;

    logic [32:0] w_sum;
    data_t       w_data;
    resp_t       w_resp;

    // Second operand comes straight from the input port on the OP2 edge.
    always_comb begin
        w_sum  = {1'b0, r_op1} + {1'b0, i_data};
        w_data = '0;
        w_resp = RESP_ERR;
        case (r_cmd)
            CMD_ADD: begin
                if (!w_sum[32]) begin
                    w_data = w_sum[31:0];
                    w_resp = RESP_OK;
                end
            end
            CMD_SUB: begin
                if (i_data <= r_op1) begin
                    w_data = r_op1 - i_data;
                    w_resp = RESP_OK;
                end
            end
            CMD_SHL: begin
                w_data = r_op1 << i_data[4:0];
                w_resp = RESP_OK;
            end
            CMD_SHR: begin
                w_data = r_op1 >> i_data[4:0];
                w_resp = RESP_OK;
            end
            default: begin
                w_data = '0;
                w_resp = RESP_ERR;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cmd   <= CMD_NOP;
            r_op1   <= '0;
            r_data  <= '0;
            r_resp  <= RESP_NONE;
        end else begin
            case (r_state)
                IDLE: begin
                    r_data <= '0;
                    r_resp <= RESP_NONE;
                    if (i_cmd != CMD_NOP) begin
                        r_cmd   <= i_cmd;
                        r_op1   <= i_data;
                        r_state <= OP2;
                    end
                end
                OP2: begin
                    r_data  <= w_data;
                    r_resp  <= w_resp;
                    r_state <= IDLE;
                end
                default: begin
                    r_data  <= '0;
                    r_resp  <= RESP_NONE;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_data = r_data;
    assign o_resp = r_resp;

endmodule

// File: rtl/calc1.sv
// Four-port 32-bit integer calculator; each port is an independent
// calc1_port sharing one clock and a reset formed from any reset bit.
module calc1
    import calc1_pkg::*;
(
    input  logic        c_clk,
    input  logic [1:7]  reset,
    input  logic [0:3]  req1_cmd_in,
    input  logic [0:31] req1_data_in,
    input  logic [0:3]  req2_cmd_in,
    input  logic [0:31] req2_data_in,
    input  logic [0:3]  req3_cmd_in,
    input  logic [0:31] req3_data_in,
    input  logic [0:3]  req4_cmd_in,
    input  logic [0:31] req4_data_in,
    output logic [0:31] out_data1,
    output logic [0:1]  out_resp1,
    output logic [0:31] out_data2,
    output logic [0:1]  out_resp2,
    output logic [0:31] out_data3,
    output logic [0:1]  out_resp3,
    output logic [0:31] out_data4,
    output logic [0:1]  out_resp4
);

    logic  w_rst;
    data_t w_data1, w_data2, w_data3, w_data4;
    resp_t w_resp1, w_resp2, w_resp3, w_resp4;

    assign w_rst = |reset;

    // Big-endian port vectors map MSB-to-MSB onto the little-endian internals.
    calc1_port u_port1 (
        .i_clk  (c_clk),
        .i_rst  (w_rst),
        .i_cmd  (req1_cmd_in),
        .i_data (req1_data_in),
        .o_data (w_data1),
        .o_resp (w_resp1)
    );

    calc1_port u_port2 (
        .i_clk  (c_clk),
        .i_rst  (w_rst),
        .i_cmd  (req2_cmd_in),
        .i_data (req2_data_in),
        .o_data (w_data2),
        .o_resp (w_resp2)
    );

    calc1_port u_port3 (
        .i_clk  (c_clk),
        .i_rst  (w_rst),
        .i_cmd  (req3_cmd_in),
        .i_data (req3_data_in),
        .o_data (w_data3),
        .o_resp (w_resp3)
    );

    calc1_port u_port4 (
        .i_clk  (c_clk),
        .i_rst  (w_rst),
        .i_cmd  (req4_cmd_in),
        .i_data (req4_data_in),
        .o_data (w_data4),
        .o_resp (w_resp4)
    );

    assign out_data1 = w_data1;
    assign out_resp1 = w_resp1;
    assign out_data2 = w_data2;
    assign out_resp2 = w_resp2;
    assign out_data3 = w_data3;
    assign out_resp3 = w_resp3;
    assign out_data4 = w_data4;
    assign out_resp4 = w_resp4;

endmodule

// File: tb/tb_calc1.sv
// Self-checking bench for calc1: directed vector table, hand sequences for
// multi-cycle cases, and randomized traffic against a behavioural model.
module tb_calc1;

    logic        clk = 1'b0;
    logic [1:7]  rst;
    logic [3:0]  cmd  [1:4];
    logic [31:0] din  [1:4];
    logic [31:0] dout [1:4];
    logic [1:0]  resp [1:4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    calc1 dut (
        .c_clk        (clk),
        .reset        (rst),
        .req1_cmd_in  (cmd[1]),
        .req1_data_in (din[1]),
        .req2_cmd_in  (cmd[2]),
        .req2_data_in (din[2]),
        .req3_cmd_in  (cmd[3]),
        .req3_data_in (din[3]),
        .req4_cmd_in  (cmd[4]),
        .req4_data_in (din[4]),
        .out_data1    (dout[1]),
        .out_resp1    (resp[1]),
        .out_data2    (dout[2]),
        .out_resp2    (resp[2]),
        .out_data3    (dout[3]),
        .out_resp3    (resp[3]),
        .out_data4    (dout[4]),
        .out_resp4    (resp[4])
    );

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  er;
        logic [31:0] ed;
    } vec_t;

    vec_t vecs [14];

    // Reference result from plain 64-bit arithmetic.
    function automatic logic [33:0] ref_calc(logic [3:0] c, logic [31:0] a, logic [31:0] b);
        longint unsigned s;
        int unsigned     sh;
        sh = b % 32;
        case (c)
            4'd1: begin
                s = 64'(a) + 64'(b);
                if (s > 64'hFFFF_FFFF) return {2'd2, 32'd0};
                return {2'd1, 32'(s)};
            end
            4'd2: begin
                if (b > a) return {2'd2, 32'd0};
                return {2'd1, 32'(64'(a) - 64'(b))};
            end
            4'd5: return {2'd1, 32'((64'(a) * (64'd1 << sh)) % 64'h1_0000_0000)};
            4'd6: return {2'd1, 32'(64'(a) / (64'd1 << sh))};
            default: return {2'd2, 32'd0};
        endcase
    endfunction

    task automatic check(string nm, logic [1:0] ar, logic [31:0] ad,
                         logic [1:0] er, logic [31:0] ed);
        checks++;
        if (ar !== er || ad !== ed) begin
            errors++;
            $display("FAIL %s: got resp=%0d data=%h, expected resp=%0d data=%h",
                     nm, ar, ad, er, ed);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(string nm);
        for (int p = 1; p <= 4; p++)
            check($sformatf("%s_p%0d", nm, p), resp[p], dout[p], 2'd0, 32'd0);
    endtask

    task automatic run_vec(int p, logic [3:0] c, logic [31:0] a, logic [31:0] b,
                           logic [1:0] er, logic [31:0] ed, string nm);
        cmd[p] = c;
        din[p] = a;
        step();
        check({nm, "_pre"}, resp[p], dout[p], 2'd0, 32'd0);
        cmd[p] = 4'd0;
        din[p] = b;
        step();
        check(nm, resp[p], dout[p], er, ed);
        din[p] = 32'd0;
        step();
        check({nm, "_post"}, resp[p], dout[p], 2'd0, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        bit          pend [1:4];
        logic [3:0]  mc   [1:4];
        logic [31:0] mop  [1:4];
        logic [33:0] expv [1:4];
        logic [3:0]  pick [12];

        vecs[0]  = '{4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000};
        vecs[1]  = '{4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 2'd1, 32'h3FFF_FFFE};
        vecs[2]  = '{4'd1, 32'h0000_0000, 32'h0000_0000, 2'd1, 32'h0000_0000};
        vecs[3]  = '{4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000};
        vecs[4]  = '{4'd2, 32'd1,         32'd15,        2'd2, 32'h0000_0000};
        vecs[5]  = '{4'd2, 32'd15,        32'd1,         2'd1, 32'd14};
        vecs[6]  = '{4'd3, 32'd1,         32'd7,         2'd2, 32'h0000_0000};
        vecs[7]  = '{4'd4, 32'd1,         32'd7,         2'd2, 32'h0000_0000};
        vecs[8]  = '{4'd5, 32'h0000_0001, 32'd31,        2'd1, 32'h8000_0000};
        vecs[9]  = '{4'd6, 32'h8000_0000, 32'h0000_0024, 2'd1, 32'h0800_0000};
        vecs[10] = '{4'd5, 32'h1234_5678, 32'h0000_0020, 2'd1, 32'h1234_5678};
        vecs[11] = '{4'd2, 32'd5,         32'd5,         2'd1, 32'd0};
        vecs[12] = '{4'd15, 32'd1,        32'd1,         2'd2, 32'h0000_0000};
        vecs[13] = '{4'd1, 32'hFFFF_FFFF, 32'h0000_0000, 2'd1, 32'hFFFF_FFFF};

        rst = 7'b1000000;
        for (int p = 1; p <= 4; p++) begin
            cmd[p] = 4'd0;
            din[p] = 32'd0;
        end

        // Reset held with random traffic, then idle.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            for (int p = 1; p <= 4; p++) begin
                cmd[p] = 4'($urandom_range(0, 15));
                din[p] = $urandom;
            end
            step();
            check_all_zero($sformatf("reset_c%0d", i));
        end
        rst = '0;
        for (int p = 1; p <= 4; p++) begin
            cmd[p] = 4'd0;
            din[p] = 32'd0;
        end
        for (int i = 0; i < 3; i++) begin
            step();
            check_all_zero($sformatf("idle_c%0d", i));
        end

        foreach (vecs[i])
            run_vec((i % 4) + 1, vecs[i].c, vecs[i].a, vecs[i].b,
                    vecs[i].er, vecs[i].ed, $sformatf("vec%0d", i));

        // Back-to-back on port 2: next command presented while response visible.
        cmd[2] = 4'd1; din[2] = 32'd3;
        step();
        check("b2b_pre", resp[2], dout[2], 2'd0, 32'd0);
        cmd[2] = 4'd2; din[2] = 32'd4;
        step();
        check("b2b_first", resp[2], dout[2], 2'd1, 32'd7);
        cmd[2] = 4'd2; din[2] = 32'd10;
        step();
        check("b2b_gap", resp[2], dout[2], 2'd0, 32'd0);
        cmd[2] = 4'd0; din[2] = 32'd3;
        step();
        check("b2b_second", resp[2], dout[2], 2'd1, 32'd7);
        din[2] = 32'd0;
        step();
        check("b2b_post", resp[2], dout[2], 2'd0, 32'd0);

        // All four ports in the same cycle.
        for (int p = 1; p <= 4; p++) begin
            cmd[p] = 4'd1;
            din[p] = 32'(p) * 32'h1000;
        end
        step();
        check_all_zero("conc_pre");
        for (int p = 1; p <= 4; p++) begin
            cmd[p] = 4'd0;
            din[p] = 32'(p);
        end
        step();
        for (int p = 1; p <= 4; p++)
            check($sformatf("conc_p%0d", p), resp[p], dout[p], 2'd1, 32'(p) * 32'h1001);
        step();
        check_all_zero("conc_post");

        for (int k = 0; k < 15; k++)
            run_vec((k % 4) + 1, 4'd1, 32'd1 << k, 32'd0, 2'd1, 32'd1 << k,
                    $sformatf("sweep%0d", k));

        // Reset during OP2 on port 3 via a non-first reset bit.
        cmd[3] = 4'd1; din[3] = 32'd5;
        step();
        cmd[3] = 4'd0; din[3] = 32'd6;
        rst = 7'b0001000;
        step();
        check("rst_op2", resp[3], dout[3], 2'd0, 32'd0);
        rst = '0;
        din[3] = 32'd0;
        step();
        check("rst_op2_after", resp[3], dout[3], 2'd0, 32'd0);
        run_vec(3, 4'd1, 32'd5, 32'd6, 2'd1, 32'd11, "rst_recover");

        // Randomized traffic against the behavioural model.
        pick = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd5, 4'd6, 4'd3, 4'd4, 4'd9, 4'd15};
        for (int p = 1; p <= 4; p++) pend[p] = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            rst = ($urandom_range(0, 39) == 0) ? 7'(7'd1 << $urandom_range(0, 6)) : 7'd0;
            for (int p = 1; p <= 4; p++) begin
                cmd[p] = pick[$urandom_range(0, 11)];
                din[p] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                if (rst != 0) begin
                    expv[p] = '0;
                    pend[p] = 1'b0;
                end else if (pend[p]) begin
                    expv[p] = ref_calc(mc[p], mop[p], din[p]);
                    pend[p] = 1'b0;
                end else begin
                    expv[p] = '0;
                    if (cmd[p] != 4'd0) begin
                        pend[p] = 1'b1;
                        mc[p]   = cmd[p];
                        mop[p]  = din[p];
                    end
                end
            end
            step();
            for (int p = 1; p <= 4; p++)
                check($sformatf("rand_t%0d_p%0d", t, p), resp[p], dout[p],
                      expv[p][33:32], expv[p][31:0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
